// File: rtl/d2_uop_sequencer.sv
// rtl/d2_uop_sequencer.sv - second decode stage: expands one instruction into 1..MAX_UOPS micro-ops
//
// Purpose: holds one decoded instruction and emits its micro-ops one per cycle,
//   with register fields, a format-specific immediate, source chaining across
//   sub-uops, an end-of-instruction mark and flush support.
// Ports:
//   clk, rst (async active-low), flush
//   in_valid/in_ready handshake with pc_in, exception_in, uop_count,
//     opcode_format, instruction_in
//   out_valid/out_ready handshake with uop, uop_idx, eoi, dr, sr1, sr2, imm,
//     use_imm, pc_out, exception_out
module d2_uop_sequencer #(
  parameter  int XLEN     = 32,
  parameter  int REG_W    = 5,
  parameter  int MAX_UOPS = 4,
  localparam int CNT_W    = $clog2(MAX_UOPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             exception_in,
  input  logic [CNT_W-1:0] uop_count,
  input  logic [4:0]       opcode_format,
  input  logic [31:0]      instruction_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      uop,
  output logic [CNT_W-1:0] uop_idx,
  output logic             eoi,
  output logic [REG_W-1:0] dr,
  output logic [REG_W-1:0] sr1,
  output logic [REG_W-1:0] sr2,
  output logic [XLEN-1:0]  imm,
  output logic             use_imm,
  output logic [XLEN-1:0]  pc_out,
  output logic             exception_out
);

  typedef enum logic {EMPTY = 1'b0, EXPAND = 1'b1} state_t;

  localparam logic [4:0] FMT_R = 5'd0;
  localparam logic [4:0] FMT_I = 5'd1;
  localparam logic [4:0] FMT_S = 5'd2;
  localparam logic [4:0] FMT_B = 5'd3;
  localparam logic [4:0] FMT_U = 5'd4;
  localparam logic [4:0] FMT_J = 5'd5;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] last_q;
  logic [31:0]      instr_q;
  logic [XLEN-1:0]  pc_q;
  logic [4:0]       fmt_q;
  logic             exc_q;

  logic             at_last;
  logic             accept;
  logic             xfer;
  logic             in_illegal;
  logic             held_illegal;
  logic [31:0]      imm32;

  assign at_last      = (idx_q == last_q);
  assign in_illegal   = (opcode_format > FMT_J);
  assign held_illegal = (fmt_q > FMT_J);

  // A new instruction may enter while the last uop of the current one leaves.
  assign in_ready  = rst && !flush && ((state_q == EMPTY) || (out_ready && at_last));
  assign out_valid = (state_q == EXPAND);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (flush) begin
      state_d = EMPTY;
      idx_d   = '0;
    end else if (accept) begin
      state_d = EXPAND;
      idx_d   = '0;
    end else if (xfer) begin
      if (!at_last) begin
        idx_d = idx_q + CNT_W'(1);
      end else begin
        state_d = EMPTY;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      last_q  <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      fmt_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        instr_q <= instruction_in;
        pc_q    <= pc_in;
        fmt_q   <= opcode_format;
        exc_q   <= exception_in;
        // Faulting or illegal instructions collapse to a single uop.
        last_q  <= (exception_in || in_illegal) ? '0 : uop_count;
      end
    end
  end

  always_comb begin
    imm32 = '0;
    case (fmt_q)
      FMT_I:   imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
      FMT_S:   imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      FMT_B:   imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                        instr_q[11:8], 1'b0};
      FMT_U:   imm32 = {instr_q[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                        instr_q[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm     = XLEN'($signed(imm32));
  assign use_imm = out_valid && (fmt_q != FMT_R) && !held_illegal;

  assign uop     = instr_q;
  assign uop_idx = idx_q;
  assign pc_out  = pc_q;
  assign dr      = REG_W'(instr_q[11:7]);
  assign sr2     = REG_W'(instr_q[24:20]);
  // Later sub-uops consume the result of the previous sub-uop.
  assign sr1     = (idx_q != '0) ? REG_W'(instr_q[11:7]) : REG_W'(instr_q[19:15]);

  assign eoi           = out_valid && at_last;
  assign exception_out = out_valid && (exc_q || held_illegal);

endmodule

// File: tb/tb_d2_uop_sequencer.sv
// tb/tb_d2_uop_sequencer.sv - self-checking bench for d2_uop_sequencer
module tb_d2_uop_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_in;
  logic        exception_in;
  logic [1:0]  uop_count;
  logic [4:0]  opcode_format;
  logic [31:0] instruction_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] uop;
  logic [1:0]  uop_idx;
  logic        eoi;
  logic [4:0]  dr, sr1, sr2;
  logic [31:0] imm;
  logic        use_imm;
  logic [31:0] pc_out;
  logic        exception_out;

  d2_uop_sequencer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in),
    .exception_in(exception_in), .uop_count(uop_count),
    .opcode_format(opcode_format), .instruction_in(instruction_in),
    .out_valid(out_valid), .out_ready(out_ready), .uop(uop), .uop_idx(uop_idx),
    .eoi(eoi), .dr(dr), .sr1(sr1), .sr2(sr2), .imm(imm), .use_imm(use_imm),
    .pc_out(pc_out), .exception_out(exception_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  fmt;
    logic [1:0]  cnt;
    logic        exc;
    logic [31:0] pc;
    logic [31:0] eimm;
    logic        euse;
  } vec_t;

  typedef struct {
    logic [31:0] uop;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  dr, sr1, sr2;
    logic [1:0]  idx;
    logic        eoi, use_imm, exc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_imm;
  logic        cur_use;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_instr();
    exp_t e;
    logic       bad;
    logic [1:0] last;
    bad  = exception_in || (opcode_format > 5'd5);
    last = bad ? 2'd0 : uop_count;
    for (int i = 0; i <= int'(last); i++) begin
      e.uop     = instruction_in;
      e.pc      = pc_in;
      e.imm     = cur_imm;
      e.use_imm = cur_use;
      e.dr      = instruction_in[11:7];
      e.sr1     = (i == 0) ? instruction_in[19:15] : instruction_in[11:7];
      e.sr2     = instruction_in[24:20];
      e.idx     = 2'(i);
      e.eoi     = (i == int'(last));
      e.exc     = bad;
      q.push_back(e);
    end
  endtask

  // Called at the falling edge: score any uop transfer, then record an accept.
  task automatic observe();
    exp_t e;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_uop actual=%h expected=none", uop);
      end else begin
        e = q.pop_front();
        chk("uop", uop, e.uop);
        chk("pc_out", pc_out, e.pc);
        chk("imm", imm, e.imm);
        chk("use_imm", 32'(use_imm), 32'(e.use_imm));
        chk("dr", 32'(dr), 32'(e.dr));
        chk("sr1", 32'(sr1), 32'(e.sr1));
        chk("sr2", 32'(sr2), 32'(e.sr2));
        chk("uop_idx", 32'(uop_idx), 32'(e.idx));
        chk("eoi", 32'(eoi), 32'(e.eoi));
        chk("exception_out", 32'(exception_out), 32'(e.exc));
      end
    end
    if (in_valid && in_ready) push_instr();
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    instruction_in = v.ins;
    opcode_format  = v.fmt;
    uop_count      = v.cnt;
    exception_in   = v.exc;
    pc_in          = v.pc;
    cur_imm        = v.eimm;
    cur_use        = v.euse;
    in_valid       = 1'b1;
  endtask

  task automatic send(input vec_t v);
    logic done;
    done = 1'b0;
    drive(v);
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      done = in_valid && in_ready;
      observe();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && (q.size() != 0 || out_valid); t++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_eoi"}, 32'(eoi), 32'd0);
    chk({tag, "_exception_out"}, 32'(exception_out), 32'd0);
    chk({tag, "_use_imm"}, 32'(use_imm), 32'd0);
    chk({tag, "_uop"}, uop, 32'd0);
    chk({tag, "_regs"}, 32'({dr, sr1, sr2, uop_idx}), 32'd0);
    chk({tag, "_imm"}, imm, 32'd0);
    chk({tag, "_pc_out"}, pc_out, 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  vec_t vecs[11];
  vec_t r3;

  initial begin
    int rdy[4]  = '{1, 0, 1, 1};
    int eidx[4] = '{0, 1, 1, 2};
    int eir[4]  = '{0, 0, 0, 1};
    int eeoi[4] = '{0, 0, 0, 1};

    vecs[0]  = '{32'hFFF30293, 5'd1, 2'd0, 1'b0, 32'h00001000, 32'hFFFFFFFF, 1'b1};
    vecs[1]  = '{32'h123450B7, 5'd4, 2'd0, 1'b0, 32'h00001004, 32'h12345000, 1'b1};
    vecs[2]  = '{32'h0000006F, 5'd5, 2'd0, 1'b0, 32'h00001008, 32'h00000000, 1'b1};
    vecs[3]  = '{32'hFE000EE3, 5'd3, 2'd0, 1'b0, 32'h0000100C, 32'hFFFFFFFC, 1'b1};
    vecs[4]  = '{32'hFE000E63, 5'd3, 2'd0, 1'b0, 32'h00001010, 32'hFFFFF7FC, 1'b1};
    vecs[5]  = '{32'hFE112E23, 5'd2, 2'd0, 1'b0, 32'h00001014, 32'hFFFFFFFC, 1'b1};
    vecs[6]  = '{32'h7FF000EF, 5'd5, 2'd0, 1'b0, 32'h00001018, 32'h00000FFE, 1'b1};
    vecs[7]  = '{32'h00B50533, 5'd0, 2'd3, 1'b0, 32'h0000101C, 32'h00000000, 1'b0};
    vecs[8]  = '{32'h00B50533, 5'd1, 2'd3, 1'b1, 32'h00001020, 32'h0000000B, 1'b1};
    vecs[9]  = '{32'hFFF30293, 5'd7, 2'd2, 1'b0, 32'h00001024, 32'h00000000, 1'b0};
    vecs[10] = '{32'h00A48493, 5'd1, 2'd1, 1'b0, 32'h00001028, 32'h0000000A, 1'b1};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    pc_in = '0; exception_in = 1'b0; uop_count = '0; opcode_format = '0;
    instruction_in = '0; cur_imm = '0; cur_use = 1'b0;

    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Table vectors issued back to back with the output always ready.
    foreach (vecs[i]) send(vecs[i]);
    drain();

    // Backpressure on a 3-uop R-type.
    r3 = '{32'h00C58633, 5'd0, 2'd2, 1'b0, 32'h00002000, 32'h0, 1'b0};
    send(r3);
    for (int i = 0; i < 4; i++) begin
      out_ready = rdy[i][0];
      @(negedge clk);
      chk("bp_idx", 32'(uop_idx), 32'(eidx[i]));
      chk("bp_in_ready", 32'(in_ready), 32'(eir[i]));
      chk("bp_eoi", 32'(eoi), 32'(eeoi[i]));
      observe();
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // Flush at idx 1 of a 4-uop instruction with a new input waiting.
    r3 = '{32'h00C58633, 5'd0, 2'd3, 1'b0, 32'h00003000, 32'h0, 1'b0};
    send(r3);
    tick();
    drive('{32'h00D686B3, 5'd0, 2'd0, 1'b0, 32'h00004000, 32'h0, 1'b0});
    flush = 1'b1;
    @(negedge clk);
    chk("flush_idx", 32'(uop_idx), 32'd1);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    observe();
    q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_next_in_ready", 32'(in_ready), 32'd1);
    observe();
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Asynchronous reset while holding idx 2.
    r3 = '{32'h00E78733, 5'd0, 2'd3, 1'b0, 32'h00005000, 32'h0, 1'b0};
    send(r3);
    tick();
    tick();
    out_ready = 1'b0;
    chk("pre_reset_idx", 32'(uop_idx), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("after_midreset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    r3 = '{32'hFFF30293, 5'd1, 2'd0, 1'b0, 32'h00006000, 32'hFFFFFFFF, 1'b1};
    send(r3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
